axi_lite_master: RTL

//  AXI4-Lite initiator: turns single-beat commands from an internal requester
//  (PS bridge, test sequencer, config engine) into AW/W/B or AR/R transactions
//  and returns one response per command. One transaction outstanding at a time.

---
 rtl/axi_lite_master.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//
// AXI4-Lite initiator. Converts single-beat commands from an internal requester
// into AW/W/B or AR/R transactions and returns exactly one response per
// command. Only one transaction is outstanding at a time.
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | cmd_ready high, waiting for a command
//   WR_REQ  | AW and W channels presented; each completes independently
//   WR_RESP | BREADY high, waiting for B beat (timeout counter running)
//   RD_REQ  | AR channel presented
//   RD_RESP | RREADY high, waiting for R beat (timeout counter running)
//   RSP     | response presented to requester, held until rsp_ready
//   DRAIN   | after a timeout, swallow the late B/R beat before going idle
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_*_i / cmd_ready_o   command channel from the requester
//   rsp_*_o / rsp_ready_i   response channel back to the requester
//   aw*, w*, b*             AXI4-Lite write address / data / response
//   ar*, r*                 AXI4-Lite read address / data
//
// Parameters
//   TIMEOUT_CYCLES  cycles of waiting for B/R before a synthesized SLVERR
//                   response is produced; 0 disables the timeout
//   PROT            constant value driven on AWPROT/ARPROT
// -----------------------------------------------------------------------------
module axi_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  PROT           = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_resp_o,
    output logic        rsp_timeout_o,

    output logic [31:0] awaddr_o,
    output logic [2:0]  awprot_o,
    output logic        awvalid_o,
    input  logic        awready_i,

    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wvalid_o,
    input  logic        wready_i,

    input  logic        bvalid_i,
    input  logic [1:0]  bresp_i,
    output logic        bready_o,

    output logic [31:0] araddr_o,
    output logic [2:0]  arprot_o,
    output logic        arvalid_o,
    input  logic        arready_i,

    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        rready_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Down-counter loaded with TIMEOUT_CYCLES-1 on entry to a *_RESP state;
    // terminal count (zero) in a waiting cycle means TIMEOUT_CYCLES cycles
    // have elapsed with READY high and no beat.
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LOAD =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    // Late beat already swallowed while the timeout response was pending.
    logic             late_done_q, late_done_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic aw_done, w_done;

    assign aw_hs = awvalid_q & awready_i;
    assign w_hs  = wvalid_q & wready_i;
    assign ar_hs = arvalid_q & arready_i;
    assign b_hs  = bvalid_i & bready_q;
    assign r_hs  = rvalid_i & rready_q;

    // A channel counts as done once its VALID has dropped or it handshakes now.
    assign aw_done = ~awvalid_q | aw_hs;
    assign w_done  = ~wvalid_q | w_hs;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        araddr_d      = araddr_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        tmo_cnt_d     = tmo_cnt_q;
        late_done_d   = late_done_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write_i) begin
                        awaddr_d  = cmd_addr_i;
                        wdata_d   = cmd_wdata_i;
                        wstrb_d   = cmd_wstrb_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr_i;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end

            S_WR_REQ: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    tmo_cnt_d = TMO_LOAD;
                    state_d   = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = bresp_i;
                    rsp_rdata_d   = 32'h0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RSP;
                end else if (TMO_EN) begin
                    if (tmo_cnt_q == '0) begin
                        // BREADY stays high so the late beat can be drained.
                        rsp_resp_d    = RESP_SLVERR;
                        rsp_rdata_d   = 32'h0;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        late_done_d   = 1'b0;
                        state_d       = S_RSP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - 1'b1;
                    end
                end
            end

            S_RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    tmo_cnt_d = TMO_LOAD;
                    state_d   = S_RD_RESP;
                end
            end

            S_RD_RESP: begin
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_resp_d    = rresp_i;
                    rsp_rdata_d   = rdata_i;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RSP;
                end else if (TMO_EN) begin
                    if (tmo_cnt_q == '0) begin
                        rsp_resp_d    = RESP_SLVERR;
                        rsp_rdata_d   = 32'h0;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        late_done_d   = 1'b0;
                        state_d       = S_RSP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - 1'b1;
                    end
                end
            end

            S_RSP: begin
                // READY is only still high here after a timeout; a late beat
                // landing now is swallowed so DRAIN is not entered needlessly.
                if (b_hs || r_hs) begin
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    late_done_d = 1'b1;
                end
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_timeout_q && !(late_done_q || b_hs || r_hs)) begin
                        state_d = S_DRAIN;
                    end else begin
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_DRAIN: begin
                if (b_hs || r_hs) begin
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            awaddr_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
            araddr_q      <= 32'h0;
            rsp_rdata_q   <= 32'h0;
            rsp_resp_q    <= 2'b00;
            tmo_cnt_q     <= '0;
            late_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            araddr_q      <= araddr_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            tmo_cnt_q     <= tmo_cnt_d;
            late_done_q   <= late_done_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign awaddr_o      = awaddr_q;
    assign awprot_o      = PROT;
    assign awvalid_o     = awvalid_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = wstrb_q;
    assign wvalid_o      = wvalid_q;
    assign bready_o      = bready_q;
    assign araddr_o      = araddr_q;
    assign arprot_o      = PROT;
    assign arvalid_o     = arvalid_q;
    assign rready_o      = rready_q;

endmodule
